// File: rtl/ecc_modadd_pkg.sv
// ecc_modadd_pkg: shared widths, field prime, op encoding, scheduler states and NEG_P helper
package ecc_modadd_pkg;
    localparam int ECC_W = 256;
    localparam int ADD_W = 257;
    localparam logic [ECC_W-1:0] P_SECP256K1 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_P3, S_RSP} state_t;
    function automatic logic [ADD_W-1:0] neg_p(input logic [ECC_W-1:0] p);
        return ADD_W'(0) - {1'b0, p};
    endfunction
endpackage

// File: rtl/brent_kung_adder257.sv
// brent_kung_adder257: 257-bit parallel-prefix adder without carry-in
// Ports: a, b (257-bit operands); sum (258-bit, bit 257 is the carry-out).
module brent_kung_adder257 (
    input  logic [256:0] a,
    input  logic [256:0] b,
    output logic [257:0] sum
);
    localparam int W = 257;
    logic [W-1:0] p, g, gp;
    always_comb begin
        p  = a ^ b;
        g  = a & b;
        gp = p;
        for (int l = 0; l < 8; l++)
            for (int i = (2 << l) - 1; i < W; i += 2 << l) begin
                g[i]  = g[i] | (gp[i] & g[i - (1 << l)]);
                gp[i] = gp[i] & gp[i - (1 << l)];
            end
        for (int l = 7; l >= 0; l--)
            for (int i = (3 << l) - 1; i < W; i += 2 << l) begin
                g[i]  = g[i] | (gp[i] & g[i - (1 << l)]);
                gp[i] = gp[i] & gp[i - (1 << l)];
            end
    end
    // g[i] now holds the carry out of bit i
    assign sum = {g[W-1], p ^ {g[W-2:0], 1'b0}};
endmodule

// File: rtl/ecc_rr_arb.sv
// ecc_rr_arb: round-robin arbiter with combinational grant
// Ports: clk, rst_n (async, active-low); req (request vector); take (a grant was
// consumed, advance pointer); grant (one-hot); grant_id (index of grant).
module ecc_rr_arb #(
    parameter int NREQ = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic                    take,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_id
);
    localparam int IW = $clog2(NREQ);
    logic [IW-1:0] last;
    int idx;
    // scan farthest-to-nearest from last+1 so the nearest requester is written last and wins
    always_comb begin
        grant    = '0;
        grant_id = '0;
        idx      = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_id   = IW'(idx);
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last <= IW'(NREQ - 1);
        else if (take) last <= grant_id;
endmodule

// File: rtl/ecc_modadd_sched.sv
// ecc_modadd_sched: constant-time add/sub mod P for NREQ requesters sharing one 257-bit adder
// Ports: clk; rst_n (async, active-low); req_valid/req_ready/req_op per requester;
// req_a/req_b packed 256-bit operands (requester i owns [256i+255:256i]);
// rsp_valid one-cycle pulse with rsp_id/rsp_data; busy (not IDLE).
// Build option: ECC_MODADD_SUB_EN enables subtraction (P3 pass); otherwise every op is an add.
module ecc_modadd_sched
    import ecc_modadd_pkg::*;
#(
    parameter int               NREQ = 2,
    parameter logic [ECC_W-1:0] P    = P_SECP256K1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0]         req_op,
    input  logic [NREQ*ECC_W-1:0]   req_a,
    input  logic [NREQ*ECC_W-1:0]   req_b,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [ECC_W-1:0]        rsp_data,
    output logic                    busy
);
    localparam int IW = $clog2(NREQ);
    localparam logic [ADD_W-1:0] NEG_P = neg_p(P);
`ifdef ECC_MODADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif
    state_t           state, state_nx;
    logic [ECC_W-1:0] a_r, b_r;
    logic             op_r, is_sub, idle, xfer;
    logic [IW-1:0]    id_r, gnt_id;
    logic [NREQ-1:0]  gnt;
    logic [ADD_W-1:0] s1, op_x, op_y;
    logic [ADD_W:0]   sum;
`ifdef ECC_MODADD_SUB_EN
    logic [ADD_W-1:0] s2;
    logic             c1;
`endif
    assign idle   = state == S_IDLE;
    assign xfer   = |(req_valid & req_ready);
    assign is_sub = SUB_EN && op_r == OP_SUB;

    ecc_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk(clk), .rst_n(rst_n), .req(req_valid), .take(xfer),
        .grant(gnt), .grant_id(gnt_id)
    );

    brent_kung_adder257 u_add (.a(op_x), .b(op_y), .sum(sum));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = xfer ? S_P1 : S_IDLE;
            S_P1:    state_nx = S_P2;
            S_P2:    state_nx = is_sub ? S_P3 : S_RSP;
`ifdef ECC_MODADD_SUB_EN
            S_P3:    state_nx = S_RSP;
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = gnt & {NREQ{idle & rst_n}};
        busy      = !idle;
        rsp_valid = state == S_RSP;
        op_x      = {1'b0, a_r};
        op_y      = {1'b0, b_r};
        if (state == S_P2) begin
            op_x = s1;
            op_y = NEG_P;
        end
`ifdef ECC_MODADD_SUB_EN
        if (state == S_P1 && is_sub) begin
            op_x = {1'b0, ~b_r};
            op_y = ADD_W'(1);
        end
        if (state == S_P2 && is_sub) begin
            op_x = {1'b0, a_r};
            op_y = s1;
        end
        if (state == S_P3) begin
            op_x = s2;
            op_y = {1'b0, P};
        end
`endif
    end

    // sub passes never reach bit 257; their carry of interest is bit 256 (the 256-bit carry-out)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= 1'b0;
            id_r     <= '0;
            s1       <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
`ifdef ECC_MODADD_SUB_EN
            s2       <= '0;
            c1       <= 1'b0;
`endif
        end else begin
            if (xfer) begin
                a_r  <= req_a[32'(gnt_id)*ECC_W +: ECC_W];
                b_r  <= req_b[32'(gnt_id)*ECC_W +: ECC_W];
                op_r <= req_op[gnt_id];
                id_r <= gnt_id;
            end
            if (state == S_P1) s1 <= sum[ADD_W-1:0];
            // add: carry out of s1+NEG_P means s1 >= P
            if (state == S_P2 && !is_sub) begin
                rsp_id   <= id_r;
                rsp_data <= sum[ADD_W] ? sum[ECC_W-1:0] : s1[ECC_W-1:0];
            end
`ifdef ECC_MODADD_SUB_EN
            if (state == S_P1) c1 <= sum[ECC_W];
            if (state == S_P2) s2 <= sum[ADD_W-1:0];
            // c1 covers b=0, where ~b+1 wraps and d alone would not show the carry
            if (state == S_P3) begin
                rsp_id   <= id_r;
                rsp_data <= (c1 | s2[ECC_W]) ? s2[ECC_W-1:0] : sum[ECC_W-1:0];
            end
`endif
        end
    end
endmodule

// File: tb/tb_ecc_modadd_sched.sv
// tb_ecc_modadd_sched: scoreboard bench for ecc_modadd_sched (latency, arbitration, reset, results)
module tb_ecc_modadd_sched;
    import ecc_modadd_pkg::*;
`ifdef ECC_MODADD_SUB_EN
    localparam bit SUB_ON = 1'b1;
`else
    localparam bit SUB_ON = 1'b0;
`endif
    localparam int NREQ = 2;
    localparam logic [255:0] PM = P_SECP256K1;

    logic         clk = 1'b0, rst_n = 1'b1;
    logic [1:0]   req_valid = '0, req_op = '0;
    logic [1:0]   req_ready;
    logic [511:0] req_a = '0, req_b = '0;
    logic         rsp_valid, busy;
    logic [0:0]   rsp_id;
    logic [255:0] rsp_data;

    ecc_modadd_sched #(.NREQ(NREQ), .P(PM)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [255:0] data; int t; int lat; } exp_t;
    typedef struct { int id; bit op; logic [255:0] a; logic [255:0] b; } op_t;

    exp_t sbq[$];
    op_t  pend[$];
    int   grants[$];
    exp_t e;
    int   cyc = 0, vectors = 0, miscompares = 0, mlast = 1, free_at = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] model(input bit op, input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        if (op && SUB_ON) s = (a >= b) ? {1'b0, a - b} : {1'b0, a} + {1'b0, PM} - {1'b0, b};
        else begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, PM}) s = s - {1'b0, PM};
        end
        return s[255:0];
    endfunction

    function automatic logic [255:0] rnd();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        if (r >= PM) r[255] = 1'b0;
        return r;
    endfunction

    // response side of the scoreboard
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_rsp: got id=%0d data=%h, required no response", rsp_id, rsp_data);
            end else begin
                e = sbq.pop_front();
                vectors++;
                if (rsp_id !== 1'(e.id)) begin
                    miscompares++;
                    $display("FAIL rsp_id: got %0d, required %0d", rsp_id, e.id);
                end
                vectors++;
                if (rsp_data !== e.data) begin
                    miscompares++;
                    $display("FAIL rsp_data: got %h, required %h", rsp_data, e.data);
                end
                vectors++;
                if (cyc - e.t != e.lat) begin
                    miscompares++;
                    $display("FAIL latency: got %0d, required %0d", cyc - e.t, e.lat);
                end
            end
        end
    end

    // drives queued ops, checks grant/busy each cycle, pushes expectations on accept
    task automatic run(input int budget);
        int n = 0, w;
        bit clr [2] = '{1'b0, 1'b0};
        logic [1:0] exp_g;
        while ((pend.size() > 0 || req_valid != 2'b00) && n < budget) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (clr[i]) begin req_valid[i] = 1'b0; clr[i] = 1'b0; end
                if (!req_valid[i])
                    for (int j = 0; j < pend.size(); j++)
                        if (pend[j].id == i) begin
                            req_valid[i] = 1'b1;
                            req_op[i] = pend[j].op;
                            req_a[i*256 +: 256] = pend[j].a;
                            req_b[i*256 +: 256] = pend[j].b;
                            pend.delete(j);
                            break;
                        end
            end
            @(negedge clk);
            exp_g = '0; w = -1;
            if (cyc >= free_at)
                for (int k = NREQ; k >= 1; k--)
                    if (req_valid[(mlast + k) % NREQ]) w = (mlast + k) % NREQ;
            if (w >= 0) exp_g[w] = 1'b1;
            vectors++;
            if (req_ready !== exp_g) begin
                miscompares++;
                $display("FAIL req_ready: got %b, required %b (cyc %0d)", req_ready, exp_g, cyc);
            end
            vectors++;
            if (busy !== 1'(cyc < free_at)) begin
                miscompares++;
                $display("FAIL busy: got %b, required %b (cyc %0d)", busy, cyc < free_at, cyc);
            end
            if (w >= 0) begin
                sbq.push_back('{w, model(req_op[w], req_a[w*256 +: 256], req_b[w*256 +: 256]),
                               cyc, (SUB_ON && req_op[w]) ? 4 : 3});
                free_at = cyc + ((SUB_ON && req_op[w]) ? 4 : 3) + 1;
                mlast = w;
                clr[w] = 1'b1;
                grants.push_back(w);
            end
            n++;
        end
        if (n >= budget) begin
            vectors++; miscompares++;
            $display("FAIL run_timeout: got %0d ops still pending, required 0", pend.size());
        end
        n = 0;
        while ((sbq.size() > 0 || busy) && n < 40) begin @(negedge clk); n++; end
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d responses outstanding, required 0", sbq.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        repeat (3) @(negedge clk);
        vectors++;
        if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b, required 00", req_ready); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
        vectors++;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
        vectors++;
        if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_id: got %0d, required 0", rsp_id); end
        vectors++;
        if (rsp_data !== '0) begin miscompares++; $display("FAIL reset_rsp_data: got %h, required 0", rsp_data); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst_n = 1'b1;
        mlast = 1;
        free_at = cyc;
    endtask

    task automatic test_add();
        pend.push_back('{0, 1'b0, 256'd5, 256'd7});
        pend.push_back('{1, 1'b0, PM - 256'd1, PM - 256'd1});
        pend.push_back('{0, 1'b0, PM - 256'd1, 256'd1});
        pend.push_back('{1, 1'b0, 256'd0, 256'd0});
        for (int i = 0; i < 4; i++) pend.push_back('{i % 2, 1'b0, rnd(), rnd()});
        run(100);
    endtask

    task automatic test_sub();
        pend.push_back('{0, 1'b1, 256'd3, 256'd5});
        pend.push_back('{0, 1'b1, 256'd5, 256'd3});
        pend.push_back('{0, 1'b1, 256'd9, 256'd0});
        pend.push_back('{0, 1'b1, 256'd0, PM - 256'd1});
        pend.push_back('{0, 1'b1, PM - 256'd1, PM - 256'd1});
        for (int i = 0; i < 3; i++) pend.push_back('{0, 1'b1, rnd(), rnd()});
        run(100);
    endtask

    task automatic test_back_to_back();
        grants.delete();
        for (int i = 0; i < 6; i++) pend.push_back('{i % 2, 1'($urandom_range(0, 1)), rnd(), rnd()});
        run(100);
        vectors++;
        if (grants.size() != 6) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d grants, required 6", grants.size());
        end
        for (int k = 1; k < grants.size(); k++) begin
            vectors++;
            if (grants[k] == grants[k-1]) begin
                miscompares++;
                $display("FAIL b2b_alternate: got grant %0d twice at %0d, required alternation", grants[k], k);
            end
        end
    endtask

    task automatic test_reset_midop();
        @(posedge clk); #1;
        req_valid = 2'b01;
        req_op[0] = 1'b1;
        req_a[255:0] = 256'd9;
        req_b[255:0] = 256'd4;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b01) begin miscompares++; $display("FAIL mid_accept: got %b, required 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_p2: got %b, required 1", busy); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_reset_busy: got %b, required 0", busy); end
        vectors++;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_rsp: got %b, required 0", rsp_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mlast = 1;
        free_at = cyc;
        repeat (6) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_dropped: got rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
            end
        end
        pend.push_back('{0, 1'b0, 256'd1, 256'd1});
        run(20);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
